// File: rtl/proc_trace_pkg.sv
// proc_trace_pkg: shared trace entry layout and drop counter limit for the trace buffer.
package proc_trace_pkg;
  localparam int STAMP_MAX_W = 64;
  localparam logic [7:0] DROP_CNT_MAX = 8'd255;
  // Stamp field is sized for the widest supported counter; unused upper bits are constant zero.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [STAMP_MAX_W-1:0] stamp;
  } trace_ent_t;
endpackage

// File: rtl/proc_trace_fifo_mem.sv
// proc_trace_fifo_mem: DEPTH-entry register file, one write port, one combinational read port.
module proc_trace_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int W = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/proc_trace_buffer.sv
// proc_trace_buffer: non-stalling processor trace FIFO with cycle stamps and drop accounting.
module proc_trace_buffer
  import proc_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int STAMP_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     trace_val,
  input  logic [31:0]              trace_addr,
  input  logic [31:0]              trace_data,
  output logic                     deq_val,
  input  logic                     deq_rdy,
  output logic [31:0]              deq_addr,
  output logic [31:0]              deq_data,
  output logic [STAMP_W-1:0]       deq_stamp,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               drop_cnt,
  input  logic                     clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [STAMP_W-1:0] cyc;
  logic full, deq_fire, enq, drop;
  trace_ent_t wr_ent, rd_ent;
  assign full     = count == CW'(DEPTH);
  assign deq_val  = count != '0;
  assign deq_fire = deq_val && deq_rdy;
  // A pop in the same cycle frees a slot, so a full buffer can still accept.
  assign enq      = trace_val && (!full || deq_fire);
  assign drop     = trace_val && full && !deq_fire;
  assign wr_ent   = '{addr: trace_addr, data: trace_data, stamp: STAMP_MAX_W'(cyc)};
  proc_trace_fifo_mem #(.DEPTH(DEPTH), .W($bits(trace_ent_t))) u_mem (
    .clk(clk),
    .we(enq && rst),
    .waddr(wr_ptr),
    .raddr(rd_ptr),
    .wdata(wr_ent),
    .rdata(rd_ent)
  );
  assign deq_addr  = deq_val ? rd_ent.addr : '0;
  assign deq_data  = deq_val ? rd_ent.data : '0;
  assign deq_stamp = deq_val ? STAMP_W'(rd_ent.stamp) : '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cyc      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      cyc      <= cyc + 1'b1;
      wr_ptr   <= enq ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr   <= deq_fire ? rd_ptr + 1'b1 : rd_ptr;
      count    <= count + CW'(enq) - CW'(deq_fire);
      overflow <= !clr && (overflow || drop);
      drop_cnt <= clr ? '0 : (drop && drop_cnt != DROP_CNT_MAX) ? drop_cnt + 8'd1 : drop_cnt;
    end
endmodule

// File: tb/tb_proc_trace_buffer.sv
// tb_proc_trace_buffer: directed checks of capture, ordering, drops, clear, stamp wrap and reset.
module tb_proc_trace_buffer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic trace_val = 1'b0;
  logic [31:0] trace_addr = '0;
  logic [31:0] trace_data = '0;
  logic deq_val, deq_rdy = 1'b0, overflow, clr = 1'b0;
  logic [31:0] deq_addr, deq_data;
  logic [15:0] deq_stamp;
  logic [3:0] count;
  logic [7:0] drop_cnt;
  int total = 0;
  int bad = 0;

  proc_trace_buffer #(.DEPTH(8), .STAMP_W(16)) dut (
    .clk(clk), .rst(rst), .trace_val(trace_val), .trace_addr(trace_addr),
    .trace_data(trace_data), .deq_val(deq_val), .deq_rdy(deq_rdy),
    .deq_addr(deq_addr), .deq_data(deq_data), .deq_stamp(deq_stamp),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt), .clr(clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) tick();
    check("rst_count", 64'(count), 0);
    check("rst_deq_val", 64'(deq_val), 0);
    check("rst_overflow", 64'(overflow), 0);
    check("rst_drop_cnt", 64'(drop_cnt), 0);
    check("rst_deq_addr", 64'(deq_addr), 0);
    // release between edges: the next edge is cycle 0
    rst = 1'b1;
    repeat (3) tick();
    trace_val = 1'b1; trace_addr = 32'h200; trace_data = 32'h1;
    tick();
    trace_val = 1'b0;
    check("first_val", 64'(deq_val), 1);
    check("first_addr", 64'(deq_addr), 64'h200);
    check("first_data", 64'(deq_data), 1);
    check("first_stamp", 64'(deq_stamp), 3);
    check("first_count", 64'(count), 1);
    trace_val = 1'b1; trace_addr = 32'h204; trace_data = 32'h2; deq_rdy = 1'b1;
    tick();
    trace_val = 1'b0;
    check("partial_swap_count", 64'(count), 1);
    check("partial_swap_head", 64'(deq_addr), 64'h204);
    tick();
    deq_rdy = 1'b0;
    check("drained_val", 64'(deq_val), 0);
    trace_val = 1'b1;
    for (int i = 0; i < 8; i++) begin
      trace_addr = 32'h200 + 32'(4 * i); trace_data = 32'(i);
      tick();
    end
    trace_addr = 32'h220;
    tick();
    trace_val = 1'b0;
    check("full_count", 64'(count), 8);
    check("full_overflow", 64'(overflow), 1);
    check("full_drop_cnt", 64'(drop_cnt), 1);
    check("full_head_addr", 64'(deq_addr), 64'h200);
    check("full_head_data", 64'(deq_data), 0);
    trace_val = 1'b1; clr = 1'b1;
    tick();
    trace_val = 1'b0; clr = 1'b0;
    check("clr_wins_overflow", 64'(overflow), 0);
    check("clr_wins_drop_cnt", 64'(drop_cnt), 0);
    check("clr_wins_count", 64'(count), 8);
    trace_val = 1'b1; trace_addr = 32'h300; trace_data = 32'h33; deq_rdy = 1'b1;
    tick();
    trace_val = 1'b0;
    check("full_swap_count", 64'(count), 8);
    check("full_swap_overflow", 64'(overflow), 0);
    check("full_swap_head", 64'(deq_addr), 64'h204);
    for (int i = 1; i < 8; i++) begin
      check("order_addr", 64'(deq_addr), 64'h200 + 64'(4 * i));
      tick();
    end
    check("tail_addr", 64'(deq_addr), 64'h300);
    check("tail_data", 64'(deq_data), 64'h33);
    tick();
    deq_rdy = 1'b0;
    check("swap_drained", 64'(count), 0);
    trace_val = 1'b1;
    repeat (308) tick();
    trace_val = 1'b0;
    check("sat_drop_cnt", 64'(drop_cnt), 255);
    check("sat_overflow", 64'(overflow), 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_overflow", 64'(overflow), 0);
    check("clr_drop_cnt", 64'(drop_cnt), 0);
    deq_rdy = 1'b1;
    repeat (8) tick();
    deq_rdy = 1'b0;
    check("sat_drained", 64'(count), 0);
    rst = 1'b0;
    #2 rst = 1'b1;
    repeat (65535) tick();
    trace_val = 1'b1; trace_addr = 32'hA; trace_data = 32'hAA;
    tick();
    trace_addr = 32'hB; trace_data = 32'hBB;
    tick();
    trace_val = 1'b0;
    check("wrap_count", 64'(count), 2);
    check("wrap_first_addr", 64'(deq_addr), 64'hA);
    check("wrap_first_stamp", 64'(deq_stamp), 64'hFFFF);
    deq_rdy = 1'b1;
    tick();
    deq_rdy = 1'b0;
    check("wrap_second_addr", 64'(deq_addr), 64'hB);
    check("wrap_second_stamp", 64'(deq_stamp), 0);
    trace_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      trace_addr = 32'h400 + 32'(i);
      tick();
    end
    trace_val = 1'b0;
    check("five_stored", 64'(count), 5);
    #2 rst = 1'b0; trace_val = 1'b1;
    #1;
    check("async_count", 64'(count), 0);
    check("async_deq_val", 64'(deq_val), 0);
    check("async_deq_addr", 64'(deq_addr), 0);
    tick();
    check("no_capture_in_rst", 64'(count), 0);
    trace_addr = 32'hC;
    rst = 1'b1;
    tick();
    trace_val = 1'b0;
    check("post_rst_count", 64'(count), 1);
    check("post_rst_addr", 64'(deq_addr), 64'hC);
    check("post_rst_stamp", 64'(deq_stamp), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
